axi_pad_calib: RTL and testbench

Calibration and configuration controller for the AXI read-padding block. It drives that block's 32-bit pad-cycle override input and monitors the padded bus's read handshakes on the master side. On request it unpads the bus, measures the worst-case AR-to-R-last latency over a fixed number of read transactions, then programs the padder with that latency plus a margin. It also forwards one-shot software writes of the pad value and reports status.

---
 rtl/axi_pad_calib_if.sv | 20 ++
 rtl/axi_pad_calib.sv | 164 ++++++++++++++++
 tb/tb_axi_pad_calib.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pad_calib_if.sv
// -----------------------------------------------------------------------------
// axi_pad_calib_if
// Read-handshake tap taken on the master side of the AXI read padder.
//   ar_valid / ar_ready : AR channel handshake
//   r_valid / r_ready   : R channel handshake
//   r_last              : last beat of a read burst
// Modports:
//   master : side that drives the tap (bus fabric or testbench)
//   slave  : side that only observes it (the calibration controller)
// -----------------------------------------------------------------------------
interface axi_pad_calib_if;
   logic ar_valid;
   logic ar_ready;
   logic r_valid;
   logic r_ready;
   logic r_last;

   modport master (output ar_valid, ar_ready, r_valid, r_ready, r_last);
   modport slave  (input  ar_valid, ar_ready, r_valid, r_ready, r_last);
endinterface

// File: rtl/axi_pad_calib.sv
// -----------------------------------------------------------------------------
// axi_pad_calib
// Calibration / configuration controller for the AXI read padder. On start_i
// it unpads the bus for one cycle, measures the worst AR-to-R-last latency
// over CalibTxns reads and programs the padder with that latency + Margin.
// From IDLE it also forwards one-shot software pad writes.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i               calibration request (IDLE only)
//   sw_pad_valid_i/_i     software pad write strobe / value (IDLE only)
//   mon                   read-handshake tap (slave modport)
//   pad_cycles_i          padder readback, informational only
//   pad_cycles_o          pad override, 32'hFFFF_FFFF = no write
//   busy_o                calibration in progress
//   done_o / timeout_o    sticky outcome of the last calibration
//   max_lat_o             running maximum latency of current/last calibration
// -----------------------------------------------------------------------------
module axi_pad_calib #(
   parameter int unsigned CalibTxns     = 16,
   parameter int unsigned Margin        = 2,
   parameter int unsigned TimeoutCycles = 4096,
   parameter logic [31:0] PadFallback   = 32'd32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic                  sw_pad_valid_i,
   input  logic [31:0]           sw_pad_i,
   axi_pad_calib_if.slave        mon,
   input  logic [31:0]           pad_cycles_i,
   output logic [31:0]           pad_cycles_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  timeout_o,
   output logic [31:0]           max_lat_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_SWWR, S_UNPAD, S_WAIT_AR, S_MEASURE, S_APPLY, S_FAIL
   } state_t;

   localparam logic [31:0] NO_WRITE = 32'hFFFF_FFFF;
   localparam logic [31:0] TXN_LAST = 32'(CalibTxns);
   localparam logic [31:0] TMO_LAST = 32'(TimeoutCycles - 1);
   localparam logic [32:0] MARGIN33 = 33'(Margin);

   state_t      state_q, state_d;
   logic [31:0] sw_pad_q, result_q, max_lat_q;
   logic [31:0] lat_cnt_q, txn_cnt_q, tmo_cnt_q;
   logic        done_q, timeout_q;

   logic        ar_hs, rlast_hs, measuring, tmo_hit, last_txn;
   logic [31:0] sample_max, result_sat;
   logic [32:0] sum33;

   // Readback is informational; fold it into an intentionally unused net.
   logic unused_pad_rb;
   assign unused_pad_rb = ^pad_cycles_i;

   assign ar_hs     = mon.ar_valid & mon.ar_ready;
   assign rlast_hs  = mon.r_valid & mon.r_ready & mon.r_last;
   assign measuring = (state_q == S_WAIT_AR) || (state_q == S_MEASURE);
   // Fires on the edge where tmo_cnt would reach TimeoutCycles-1.
   assign tmo_hit   = measuring && ((tmo_cnt_q + 32'd1) >= TMO_LAST);
   assign last_txn  = (txn_cnt_q + 32'd1) == TXN_LAST;

   assign sample_max = (lat_cnt_q > max_lat_q) ? lat_cnt_q : max_lat_q;
   assign sum33      = {1'b0, sample_max} + MARGIN33;
   assign result_sat = (sum33 > 33'h0_FFFF_FFFE) ? 32'hFFFF_FFFE : sum33[31:0];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_i)             state_d = S_UNPAD;
            else if (sw_pad_valid_i) state_d = S_SWWR;
         end
         S_SWWR:    state_d = S_IDLE;
         S_UNPAD:   state_d = S_WAIT_AR;
         S_WAIT_AR: begin
            if (tmo_hit)    state_d = S_FAIL;
            else if (ar_hs) state_d = S_MEASURE;
         end
         S_MEASURE: begin
            if (tmo_hit)       state_d = S_FAIL;
            else if (rlast_hs) state_d = last_txn ? S_APPLY : S_WAIT_AR;
         end
         S_APPLY:   state_d = S_IDLE;
         S_FAIL:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Datapath: counters, captured values and sticky status.
   // NOTE: no memories here, so every register is reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sw_pad_q  <= '0;
         result_q  <= '0;
         max_lat_q <= '0;
         lat_cnt_q <= '0;
         txn_cnt_q <= '0;
         tmo_cnt_q <= '0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  done_q    <= 1'b0;
                  timeout_q <= 1'b0;
                  max_lat_q <= '0;
                  txn_cnt_q <= '0;
                  tmo_cnt_q <= '0;
               end else if (sw_pad_valid_i) begin
                  sw_pad_q  <= sw_pad_i;
               end
            end
            S_WAIT_AR: begin
               tmo_cnt_q <= tmo_cnt_q + 32'd1;
               if (ar_hs) lat_cnt_q <= 32'd1;
            end
            S_MEASURE: begin
               tmo_cnt_q <= tmo_cnt_q + 32'd1;
               if (lat_cnt_q != 32'hFFFF_FFFF) lat_cnt_q <= lat_cnt_q + 32'd1;
               if (rlast_hs) begin
                  max_lat_q <= sample_max;
                  txn_cnt_q <= txn_cnt_q + 32'd1;
                  result_q  <= result_sat;
               end
            end
            S_APPLY: done_q    <= 1'b1;
            S_FAIL:  timeout_q <= 1'b1;
            default: ;
         endcase
      end
   end

   // Outputs decode registered state only.
   always_comb begin
      pad_cycles_o = NO_WRITE;
      unique case (state_q)
         S_UNPAD: pad_cycles_o = 32'd0;
         S_SWWR:  pad_cycles_o = sw_pad_q;
         S_APPLY: pad_cycles_o = result_q;
         S_FAIL:  pad_cycles_o = PadFallback;
         default: pad_cycles_o = NO_WRITE;
      endcase
   end

   assign busy_o    = (state_q != S_IDLE) && (state_q != S_SWWR);
   assign done_o    = done_q;
   assign timeout_o = timeout_q;
   assign max_lat_o = max_lat_q;

endmodule

// File: tb/tb_axi_pad_calib.sv
// -----------------------------------------------------------------------------
// tb_axi_pad_calib
// Directed sequence with randomized latencies/gaps against a transaction-level
// reference (running maximum, max + margin) for axi_pad_calib configured with
// CalibTxns=4, Margin=2, TimeoutCycles=64, PadFallback=32.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi_pad_calib;

   localparam int unsigned N_TXN  = 4;
   localparam int unsigned MARGIN = 2;
   localparam int unsigned TMO    = 64;
   localparam logic [31:0] FALLBK = 32'd32;
   localparam logic [31:0] NOWR   = 32'hFFFF_FFFF;

   logic        clk_i = 1'b0;
   logic        rst_i, start_i, sw_pad_valid_i;
   logic [31:0] sw_pad_i, pad_cycles_i, pad_cycles_o, max_lat_o;
   logic        busy_o, done_o, timeout_o;

   int checks   = 0;
   int failures = 0;

   int lat_a [N_TXN];
   int gap_a [N_TXN];

   axi_pad_calib_if mon_if ();

   axi_pad_calib #(
      .CalibTxns     (N_TXN),
      .Margin        (MARGIN),
      .TimeoutCycles (TMO),
      .PadFallback   (FALLBK)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .start_i        (start_i),
      .sw_pad_valid_i (sw_pad_valid_i),
      .sw_pad_i       (sw_pad_i),
      .mon            (mon_if),
      .pad_cycles_i   (pad_cycles_i),
      .pad_cycles_o   (pad_cycles_o),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .timeout_o      (timeout_o),
      .max_lat_o      (max_lat_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance through one rising edge; inputs change and outputs are read 1ns later.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic start_calib(input bit with_sw);
      start_i = 1'b1;
      if (with_sw) begin
         sw_pad_valid_i = 1'b1;
         sw_pad_i       = 32'd77;
      end
      step();
      start_i = 1'b0; sw_pad_valid_i = 1'b0;
      check("unpad_pad",  pad_cycles_o, 32'd0);
      check("unpad_busy", busy_o, 1'b1);
      check("start_clr_done", done_o, 1'b0);
      check("start_clr_tmo",  timeout_o, 1'b0);
      check("start_clr_max",  max_lat_o, 32'd0);
      step();
      check("post_unpad_pad", pad_cycles_o, NOWR);
      check("post_unpad_busy", busy_o, 1'b1);
   endtask

   // Runs `count` transactions from lat_a/gap_a; completes the calibration
   // checks when count equals the full transaction count.
   task automatic do_txns(input int count, input bit stray, input bit sw_mid);
      int          run_max;
      longint      sum;
      logic [31:0] exp_pad;
      run_max = 0;
      if (stray) begin
         mon_if.r_valid = 1'b1; mon_if.r_ready = 1'b1; mon_if.r_last = 1'b1;
         step();
         mon_if.r_valid = 1'b0; mon_if.r_ready = 1'b0; mon_if.r_last = 1'b0;
      end
      for (int i = 0; i < count; i++) begin
         repeat (gap_a[i]) step();
         mon_if.ar_valid = 1'b1; mon_if.ar_ready = 1'b1;
         step();
         mon_if.ar_valid = 1'b0; mon_if.ar_ready = 1'b0;
         for (int j = 0; j < lat_a[i] - 1; j++) begin
            if (sw_mid && j == 0) begin
               sw_pad_valid_i = 1'b1;
               sw_pad_i       = 32'd5;
            end
            step();
            sw_pad_valid_i = 1'b0;
         end
         mon_if.r_valid = 1'b1; mon_if.r_ready = 1'b1; mon_if.r_last = 1'b1;
         step();
         mon_if.r_valid = 1'b0; mon_if.r_ready = 1'b0; mon_if.r_last = 1'b0;
         if (lat_a[i] > run_max) run_max = lat_a[i];
         check($sformatf("max_lat_txn%0d", i), max_lat_o, 32'(run_max));
         if (i < N_TXN - 1) begin
            check($sformatf("mid_pad_txn%0d", i), pad_cycles_o, NOWR);
         end else begin
            sum     = longint'(run_max) + longint'(MARGIN);
            exp_pad = (sum > 64'hFFFF_FFFE) ? 32'hFFFF_FFFE : 32'(sum);
            check("apply_pad",  pad_cycles_o, exp_pad);
            check("apply_busy", busy_o, 1'b1);
            check("apply_done_low", done_o, 1'b0);
            step();
            check("done_set",   done_o, 1'b1);
            check("done_busy",  busy_o, 1'b0);
            check("done_pad",   pad_cycles_o, NOWR);
            check("done_tmo",   timeout_o, 1'b0);
            check("done_max",   max_lat_o, 32'(run_max));
         end
      end
   endtask

   task automatic randomize_txns();
      for (int i = 0; i < N_TXN; i++) begin
         lat_a[i] = int'($urandom_range(1, 10));
         gap_a[i] = int'($urandom_range(0, 2));
      end
   endtask

   initial begin
      rst_i = 1'b1; start_i = 1'b1; sw_pad_valid_i = 1'b0; sw_pad_i = '0;
      pad_cycles_i = 32'd0;
      mon_if.ar_valid = 1'b0; mon_if.ar_ready = 1'b0;
      mon_if.r_valid = 1'b0; mon_if.r_ready = 1'b0; mon_if.r_last = 1'b0;

      // Reset held with start_i high: outputs stay at reset values.
      for (int c = 0; c < 3; c++) begin
         step();
         check("rst_pad",  pad_cycles_o, NOWR);
         check("rst_busy", busy_o, 1'b0);
         check("rst_done", done_o, 1'b0);
         check("rst_tmo",  timeout_o, 1'b0);
         check("rst_max",  max_lat_o, 32'd0);
      end
      rst_i = 1'b0; start_i = 1'b0;
      step();
      check("post_rst_pad",  pad_cycles_o, NOWR);
      check("post_rst_busy", busy_o, 1'b0);

      // Software writes: value for exactly one cycle, never busy.
      for (int k = 0; k < 3; k++) begin
         logic [31:0] v;
         v = (k == 0) ? 32'd40 : $urandom_range(0, 32'h7FFF_FFFF);
         sw_pad_valid_i = 1'b1; sw_pad_i = v;
         step();
         sw_pad_valid_i = 1'b0;
         pad_cycles_i = v;
         check("sw_pad",  pad_cycles_o, v);
         check("sw_busy", busy_o, 1'b0);
         step();
         check("sw_pad_after",  pad_cycles_o, NOWR);
         check("sw_busy_after", busy_o, 1'b0);
      end

      // Directed calibration: 5, 9, 7, 3 -> max 9, programmed 11.
      lat_a = '{5, 9, 7, 3};
      gap_a = '{0, 1, 0, 2};
      start_calib(1'b0);
      do_txns(N_TXN, 1'b0, 1'b0);

      // Random calibrations; also start+sw same cycle, stray R-last, sw in MEASURE.
      for (int r = 0; r < 4; r++) begin
         randomize_txns();
         start_calib(r == 0);
         do_txns(N_TXN, r == 1, r == 2);
      end

      // Timeout: no AR traffic; FAIL 64 cycles after UNPAD.
      start_calib(1'b0);
      repeat (62) step();
      check("tmo_pre_pad",  pad_cycles_o, NOWR);
      check("tmo_pre_busy", busy_o, 1'b1);
      step();
      check("fail_pad",  pad_cycles_o, FALLBK);
      check("fail_busy", busy_o, 1'b1);
      step();
      check("tmo_set",  timeout_o, 1'b1);
      check("tmo_done", done_o, 1'b0);
      check("tmo_busy", busy_o, 1'b0);
      check("tmo_pad",  pad_cycles_o, NOWR);
      check("tmo_max",  max_lat_o, 32'd0);

      // Reset in MEASURE after the second transaction: no APPLY.
      randomize_txns();
      start_calib(1'b0);
      do_txns(2, 1'b0, 1'b0);
      mon_if.ar_valid = 1'b1; mon_if.ar_ready = 1'b1;
      step();
      mon_if.ar_valid = 1'b0; mon_if.ar_ready = 1'b0;
      step();
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      check("midrst_pad",  pad_cycles_o, NOWR);
      check("midrst_busy", busy_o, 1'b0);
      check("midrst_done", done_o, 1'b0);
      check("midrst_max",  max_lat_o, 32'd0);
      for (int c = 0; c < 3; c++) begin
         step();
         check("midrst_no_apply", pad_cycles_o, NOWR);
      end

      // Full calibration afterwards.
      randomize_txns();
      start_calib(1'b0);
      do_txns(N_TXN, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
